// File: rtl/light_conflict_monitor.sv
// Safety monitor between the light sequencer and the lamp drivers; forces flashing amber on any fault.
// Latency: light_in -> lamp_out is 2 clk edges; a violating sample never reaches lamp_out.
// Backpressure: none; one sample is accepted every cycle and fault_clr is a level request.
module light_conflict_monitor #(
  parameter int MAX_GREEN   = 4,
  parameter int WDOG_CYCLES = 268435456,
  parameter int FLASH_HALF  = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] light_in,
  input  logic        fault_clr,
  output logic [29:0] lamp_out,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [7:0]  fault_cnt
);

  localparam int          LANES     = 10;
  localparam int          FW        = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [29:0] ALL_RED   = 30'o4444444444;
  localparam logic [29:0] ALL_AMBER = 30'o2222222222;
  localparam logic [29:0] ALL_DARK  = 30'o0000000000;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FAULT  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [29:0]   r_in_q;
  logic [29:0]   r_prev_q;
  logic [31:0]   r_wd_cnt;
  logic [FW-1:0] r_flash_cnt;
  logic          r_flash_on;

  logic          w_illegal;
  logic [3:0]    w_green_cnt;
  logic          w_overload;
  logic          w_skip;
  logic          w_same;
  logic          w_wdog;
  logic          w_viol;
  logic [2:0]    w_code;

  logic [29:0]   w_lamp_nxt;
  logic          w_fault_nxt;
  logic [2:0]    w_code_nxt;
  logic [7:0]    w_cnt_nxt;
  logic [31:0]   w_wd_nxt;
  logic [FW-1:0] w_flash_nxt;
  logic          w_flash_on_nxt;

  // Per-lane checks on the registered sample: legal encoding, green count, green->red without amber.
  always_comb begin
    w_illegal   = 1'b0;
    w_green_cnt = 4'd0;
    w_skip      = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (!(r_in_q[3*k +: 3] == 3'b100 ||
            r_in_q[3*k +: 3] == 3'b010 ||
            r_in_q[3*k +: 3] == 3'b001)) begin
        w_illegal = 1'b1;
      end
      if (r_in_q[3*k +: 3] == 3'b001) begin
        w_green_cnt = w_green_cnt + 4'd1;
      end
      if (r_prev_q[3*k +: 3] == 3'b001 && r_in_q[3*k +: 3] == 3'b100) begin
        w_skip = 1'b1;
      end
    end
  end

  assign w_overload = ({28'd0, w_green_cnt} > MAX_GREEN);
  assign w_same     = (r_in_q == r_prev_q);
  // This compare is the WDOG_CYCLES-th unchanged one when the count already holds WDOG_CYCLES-1.
  assign w_wdog     = w_same && (r_wd_cnt == 32'(WDOG_CYCLES - 1));
  assign w_viol     = w_illegal || w_overload || w_skip || w_wdog;

  // Lowest-numbered applicable fault wins.
  always_comb begin
    w_code = 3'd0;
    if (w_illegal) begin
      w_code = 3'd1;
    end else if (w_overload) begin
      w_code = 3'd2;
    end else if (w_skip) begin
      w_code = 3'd3;
    end else if (w_wdog) begin
      w_code = 3'd4;
    end
  end

  // Next-state and next-output logic for the NORMAL/FAULT controller.
  always_comb begin
    w_state_nxt    = r_state;
    w_lamp_nxt     = lamp_out;
    w_fault_nxt    = fault;
    w_code_nxt     = fault_code;
    w_cnt_nxt      = fault_cnt;
    w_wd_nxt       = r_wd_cnt;
    w_flash_nxt    = r_flash_cnt;
    w_flash_on_nxt = r_flash_on;
    case (r_state)
      ST_NORMAL: begin
        if (w_viol) begin
          w_state_nxt    = ST_FAULT;
          w_fault_nxt    = 1'b1;
          w_code_nxt     = w_code;
          w_cnt_nxt      = (fault_cnt == 8'hFF) ? fault_cnt : fault_cnt + 8'd1;
          w_lamp_nxt     = ALL_AMBER;
          w_flash_nxt    = '0;
          w_flash_on_nxt = 1'b1;
          w_wd_nxt       = 32'd0;
        end else begin
          w_lamp_nxt = r_in_q;
          w_wd_nxt   = w_same ? r_wd_cnt + 32'd1 : 32'd0;
        end
      end
      ST_FAULT: begin
        w_wd_nxt = 32'd0;
        // Leaving FAULT only needs a well-formed, non-overloaded sample; skip history restarts here.
        if (fault_clr && !w_illegal && !w_overload) begin
          w_state_nxt = ST_NORMAL;
          w_fault_nxt = 1'b0;
          w_code_nxt  = 3'd0;
          w_lamp_nxt  = r_in_q;
        end else if (r_flash_cnt == FW'(FLASH_HALF - 1)) begin
          w_flash_nxt    = '0;
          w_flash_on_nxt = ~r_flash_on;
          w_lamp_nxt     = r_flash_on ? ALL_DARK : ALL_AMBER;
        end else begin
          w_flash_nxt = r_flash_cnt + FW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_FAULT;
        w_fault_nxt = 1'b1;
        w_lamp_nxt  = ALL_AMBER;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_NORMAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sample pipeline, lamp drive, fault reporting and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_q      <= ALL_RED;
      r_prev_q    <= ALL_RED;
      lamp_out    <= ALL_RED;
      fault       <= 1'b0;
      fault_code  <= 3'd0;
      fault_cnt   <= 8'd0;
      r_wd_cnt    <= 32'd0;
      r_flash_cnt <= '0;
      r_flash_on  <= 1'b0;
    end else begin
      r_in_q      <= light_in;
      r_prev_q    <= r_in_q;
      lamp_out    <= w_lamp_nxt;
      fault       <= w_fault_nxt;
      fault_code  <= w_code_nxt;
      fault_cnt   <= w_cnt_nxt;
      r_wd_cnt    <= w_wd_nxt;
      r_flash_cnt <= w_flash_nxt;
      r_flash_on  <= w_flash_on_nxt;
    end
  end

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Bench for light_conflict_monitor: directed lane patterns, reference model and literal checks.
// Latency: model predicts lamp/fault state per clock edge; compared every falling edge.
// Backpressure: none; inputs change on falling edges only.
module tb_light_conflict_monitor;

  localparam int          MG   = 4;
  localparam int          WD   = 16;
  localparam int          FH   = 4;
  localparam logic [29:0] RED  = 30'o4444444444;
  localparam logic [29:0] AMB  = 30'o2222222222;
  localparam logic [29:0] DARK = 30'o0000000000;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] light_in;
  logic        fault_clr;
  logic [29:0] lamp_out;
  logic        fault;
  logic [2:0]  fault_code;
  logic [7:0]  fault_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  light_conflict_monitor #(
    .MAX_GREEN  (MG),
    .WDOG_CYCLES(WD),
    .FLASH_HALF (FH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .light_in  (light_in),
    .fault_clr (fault_clr),
    .lamp_out  (lamp_out),
    .fault     (fault),
    .fault_code(fault_code),
    .fault_cnt (fault_cnt)
  );

  // ---------------- reference model ----------------
  bit          m_valid = 1'b0;
  logic [29:0] m_s1, m_s0, m_lamp;
  bit          m_fault;
  logic [2:0]  m_code;
  int          m_cnt, m_run, m_age;

  // Fault classification of one sample against the one before it.
  function automatic logic [2:0] m_eval(input logic [29:0] cur, input logic [29:0] prv, input int run);
    int g = 0;
    bit ill = 0;
    bit sk = 0;
    logic [2:0] c, p;
    for (int k = 0; k < 10; k++) begin
      c = cur[3*k +: 3];
      p = prv[3*k +: 3];
      if (c != 3'b100 && c != 3'b010 && c != 3'b001) ill = 1;
      if (c == 3'b001) g++;
      if (p == 3'b001 && c == 3'b100) sk = 1;
    end
    if (ill) return 3'd1;
    if (g > MG) return 3'd2;
    if (sk) return 3'd3;
    if (cur == prv && run + 1 >= WD) return 3'd4;
    return 3'd0;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_valid = 1'b1;
        m_s1 = RED; m_s0 = RED; m_lamp = RED;
        m_fault = 0; m_code = 0; m_cnt = 0; m_run = 0; m_age = 0;
      end else if (m_valid) begin
        logic [29:0] cur, prv;
        logic [2:0]  code;
        cur  = m_s1;
        prv  = m_s0;
        code = m_eval(cur, prv, m_run);
        if (!m_fault) begin
          if (code != 3'd0) begin
            m_fault = 1; m_code = code; m_age = 0; m_run = 0;
            m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_lamp = AMB;
          end else begin
            m_lamp = cur;
            m_run  = (cur == prv) ? m_run + 1 : 0;
          end
        end else begin
          if (fault_clr && code != 3'd1 && code != 3'd2) begin
            m_fault = 0; m_code = 0; m_lamp = cur; m_run = 0;
          end else begin
            m_age++;
            m_lamp = (((m_age / FH) % 2) == 0) ? AMB : DARK;
          end
        end
        m_s0 = cur;
        m_s1 = light_in;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        checks++;
        if ({lamp_out, fault, fault_code, fault_cnt} !== {m_lamp, m_fault, m_code, m_cnt[7:0]}) begin
          errors++;
          $display("FAIL model t=%0t lamp=%o/%o fault=%b/%b code=%0d/%0d cnt=%0d/%0d (actual/required)",
                   $time, lamp_out, m_lamp, fault, m_fault, fault_code, m_code, fault_cnt, m_cnt[7:0]);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [29:0] setl(input logic [29:0] p, input int k, input logic [2:0] c);
    logic [29:0] r;
    r = p;
    r[3*k +: 3] = c;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0o required=%0o", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  logic [29:0] g0, a0, f4, f5, q, w, x, y, prevp;
  logic [29:0] t1 [4];

  initial begin
    rst = 1'b1; fault_clr = 1'b0; light_in = RED;
    cyc(2);
    chk("rst_lamp", 32'(lamp_out), 32'(RED));
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_code", 32'(fault_code), 32'd0);
    chk("rst_cnt", 32'(fault_cnt), 32'd0);
    rst = 1'b0;
    cyc(2);

    // Legal lane-0 cycle, lamp_out trails light_in by two edges.
    g0 = setl(RED, 0, 3'b001);
    a0 = setl(RED, 0, 3'b010);
    t1[0] = g0; t1[1] = a0; t1[2] = RED; t1[3] = g0;
    prevp = RED;
    for (int i = 0; i < 4; i++) begin
      light_in = t1[i];
      cyc(1);
      chk("t1_hold", 32'(lamp_out), 32'(prevp));
      cyc(1);
      chk("t1_lat2", 32'(lamp_out), 32'(t1[i]));
      chk("t1_nofault", 32'(fault), 32'd0);
      cyc(6);
      prevp = t1[i];
    end

    // One-cycle illegal code on lane 3, then flash timing.
    light_in = setl(g0, 3, 3'b011);
    cyc(1);
    light_in = g0;
    cyc(1);
    chk("t2_fault", 32'(fault), 32'd1);
    chk("t2_code", 32'(fault_code), 32'd1);
    chk("t2_lamp_on", 32'(lamp_out), 32'(AMB));
    chk("t2_cnt", 32'(fault_cnt), 32'd1);
    cyc(4);
    chk("t2_lamp_off", 32'(lamp_out), 32'(DARK));
    cyc(4);
    chk("t2_lamp_on2", 32'(lamp_out), 32'(AMB));

    // Clear refused while lane 2 is illegal, then accepted on a legal sample.
    light_in = setl(g0, 2, 3'b111);
    cyc(1);
    fault_clr = 1'b1;
    cyc(3);
    chk("t6_stay", 32'(fault), 32'd1);
    chk("t6_code_held", 32'(fault_code), 32'd1);
    light_in = g0;
    cyc(2);
    chk("t6_exit", 32'(fault), 32'd0);
    chk("t6_exit_lamp", 32'(lamp_out), 32'(g0));
    chk("t6_exit_code", 32'(fault_code), 32'd0);
    chk("t6_cnt_hold", 32'(fault_cnt), 32'd1);
    fault_clr = 1'b0;

    // Green overload: five greens fault, four do not.
    f5 = 30'o4444411111;
    f4 = 30'o4444441111;
    light_in = f5;
    cyc(2);
    chk("t3_code", 32'(fault_code), 32'd2);
    chk("t3_cnt", 32'(fault_cnt), 32'd2);
    light_in = RED;
    cyc(1);
    fault_clr = 1'b1;
    cyc(2);
    fault_clr = 1'b0;
    chk("t3_clear", 32'(fault), 32'd0);
    light_in = f4;
    cyc(4);
    chk("t3_four_ok", 32'(fault), 32'd0);
    chk("t3_four_lamp", 32'(lamp_out), 32'(f4));

    // Amber skip on lane 0, then a proper green->amber->red.
    q = setl(f4, 0, 3'b100);
    light_in = q;
    cyc(2);
    chk("t4_code", 32'(fault_code), 32'd3);
    chk("t4_cnt", 32'(fault_cnt), 32'd3);
    fault_clr = 1'b1;
    cyc(2);
    fault_clr = 1'b0;
    chk("t4_clear_lamp", 32'(lamp_out), 32'(q));
    light_in = setl(q, 0, 3'b001);
    cyc(2);
    light_in = setl(q, 0, 3'b010);
    cyc(2);
    light_in = q;
    cyc(4);
    chk("t4_seq_ok", 32'(fault), 32'd0);

    // Watchdog fires on the 16th unchanged compare.
    w = setl(q, 9, 3'b001);
    light_in = w;
    cyc(17);
    chk("t5_wd_early", 32'(fault), 32'd0);
    cyc(1);
    chk("t5_wd_fire", 32'(fault), 32'd1);
    chk("t5_wd_code", 32'(fault_code), 32'd4);
    chk("t5_wd_cnt", 32'(fault_cnt), 32'd4);
    fault_clr = 1'b1;
    cyc(2);
    fault_clr = 1'b0;
    // A change after 15 unchanged compares restarts the count.
    x = setl(q, 9, 3'b010);
    y = q;
    light_in = x;
    cyc(16);
    light_in = y;
    cyc(4);
    chk("t5_change_ok", 32'(fault), 32'd0);
    cyc(10);
    chk("t5_restart_ok", 32'(fault), 32'd0);

    // Reset in the middle of a flash.
    light_in = setl(y, 5, 3'b111);
    cyc(1);
    light_in = y;
    cyc(1);
    chk("t6r_fault", 32'(fault_cnt), 32'd5);
    cyc(5);
    chk("t6r_dark", 32'(lamp_out), 32'(DARK));
    rst = 1'b1;
    cyc(1);
    chk("t6r_lamp", 32'(lamp_out), 32'(RED));
    chk("t6r_cnt", 32'(fault_cnt), 32'd0);
    chk("t6r_flt", 32'(fault), 32'd0);
    rst = 1'b0;
    cyc(3);
    chk("t6r_resume", 32'(lamp_out), 32'(y));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
